// File: rtl/trace_buf_multibank.sv
// Multi-bank instruction-trace capture buffer: a two-stage capture/write pipeline feeding
// NUM_BANKS interleaved RAMs, read back as MEM_DATA_SIZE-wide rows. Optional macro: TRACE_TIMESTAMP_EN.
module trace_buf_multibank #(
    parameter logic [31:0] TRACE_BASEADDR = 32'h00100000,
    parameter int TRACE_DEPTH    = 1024,
    parameter int TRACE_WIDTH    = 36,
    parameter int NUM_BANKS      = 2,
    parameter int MEM_DATA_SIZE  = 128,
    parameter int ADDR_SIZE      = 32,
    parameter int DROP_CNT_WIDTH = 16,
    parameter int TS_WIDTH       = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      trace_enabled_i,
    input  logic                      trace_mode_i,
    input  logic                      trace_clear_i,
    input  logic                      trace_valid_i,
    input  logic [TRACE_WIDTH-1:0]    trace_data_i,
    output logic [ADDR_SIZE-1:0]      trace_ptr_o,
    output logic [ADDR_SIZE-1:0]      trace_count_o,
    output logic                      trace_overflow_o,
    output logic [DROP_CNT_WIDTH-1:0] trace_drop_cnt_o,
    input  logic                      trace_mem_en_i,
    input  logic [ADDR_SIZE-1:0]      trace_mem_addr_i,
    output logic [MEM_DATA_SIZE-1:0]  trace_mem_rdata_o
);
    localparam int PTR_W     = $clog2(TRACE_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int LOG_BANKS = $clog2(NUM_BANKS);
    localparam int BANK_W    = (LOG_BANKS > 0) ? LOG_BANKS : 1;
    localparam int ROWS      = TRACE_DEPTH / NUM_BANKS;
    localparam int ROW_W     = $clog2(ROWS);
    localparam int SLOT_W    = MEM_DATA_SIZE / NUM_BANKS;
    localparam int ROW_SHIFT = $clog2(MEM_DATA_SIZE / 8);
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = TS_WIDTH + TRACE_WIDTH;
`else
    localparam int EW = TRACE_WIDTH + 0 * TS_WIDTH;
`endif

    logic                      en_q, en_d;
    logic                      mode_q, mode_d;
    logic                      accept_q, accept_d;
    logic [EW-1:0]             entry_q, entry_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      ovf_q, ovf_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
    logic                      rvalid_q, rvalid_d;
    logic                      start, clear, full, wr_en;
    logic [BANK_W-1:0]         wr_bank;
    logic [ROW_W-1:0]          wr_row, rd_row;
    logic [ADDR_SIZE-1:0]      offset;
    logic                      unused_offset_bits;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    assign ts_d = ts_q + 1'b1;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ts_q <= '0;
        else            ts_q <= ts_d;
    end
    assign entry_d = {ts_q, trace_data_i};
`else
    assign entry_d = trace_data_i;
`endif

    always_comb begin
        start    = trace_enabled_i & ~en_q;
        clear    = trace_clear_i | start;
        full     = (count_q == CNT_W'(TRACE_DEPTH));
        // A full stop-mode buffer drops; wrap mode keeps overwriting the oldest entry.
        wr_en    = accept_q & ~clear & (~full | mode_q);
        en_d     = trace_enabled_i;
        mode_d   = start ? trace_mode_i : mode_q;
        accept_d = trace_valid_i & trace_enabled_i;
        rvalid_d = rvalid_q | trace_mem_en_i;
        ptr_d    = ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (clear) begin
            ptr_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            drop_d  = '0;
        end else if (accept_q) begin
            if (full) begin
                ovf_d = 1'b1;
                if (!mode_q && drop_q != '1) drop_d = drop_q + 1'b1;
            end
            if (wr_en) begin
                ptr_d = ptr_q + 1'b1;
                if (!full) count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            accept_q <= 1'b0;
            entry_q  <= '0;
            ptr_q    <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            en_q     <= en_d;
            mode_q   <= mode_d;
            accept_q <= accept_d;
            entry_q  <= entry_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign wr_bank            = BANK_W'(ptr_q % PTR_W'(NUM_BANKS));
    assign wr_row             = ROW_W'(ptr_q >> LOG_BANKS);
    assign offset             = trace_mem_addr_i - ADDR_SIZE'(TRACE_BASEADDR);
    // Truncating to ROW_W bits is the modulo over the bank depth.
    assign rd_row             = ROW_W'(offset >> ROW_SHIFT);
    assign unused_offset_bits = ^offset;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [EW-1:0] mem [ROWS];
            logic [EW-1:0] rd_q;
            // Memory holds no reset so it maps onto block RAM; rvalid_q masks the
            // read register until the first read after reset.
            always_ff @(posedge clk_i) begin
                if (wr_en && wr_bank == BANK_W'(gi)) mem[wr_row] <= entry_q;
                if (trace_mem_en_i) rd_q <= mem[rd_row];
            end
            assign trace_mem_rdata_o[gi*SLOT_W +: SLOT_W] = rvalid_q ? SLOT_W'(rd_q) : '0;
        end
    endgenerate

    assign trace_ptr_o      = ADDR_SIZE'(ptr_q);
    assign trace_count_o    = ADDR_SIZE'(count_q);
    assign trace_overflow_o = ovf_q;
    assign trace_drop_cnt_o = drop_q;
endmodule

// File: tb/tb_trace_buf_multibank.sv
// Bench for trace_buf_multibank: scenario table, hand-written corner sequences, and
// randomized traffic checked against a rule-level reference model.
module tb_trace_buf_multibank;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0, mode = 1'b0, clr = 1'b0, valid = 1'b0;
    logic [35:0]  data = '0;
    logic         mem_en = 1'b0;
    logic [31:0]  addr = 32'h00100000;
    logic [31:0]  ptr_o, count_o;
    logic         ovf_o;
    logic [15:0]  drop_o;
    logic [127:0] rdata_o;

    int tests = 0;
    int fails = 0;

    trace_buf_multibank #(
        .TRACE_BASEADDR(32'h00100000), .TRACE_DEPTH(DEPTH), .TRACE_WIDTH(36),
        .NUM_BANKS(2), .MEM_DATA_SIZE(128), .ADDR_SIZE(32),
        .DROP_CNT_WIDTH(16), .TS_WIDTH(16)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .trace_enabled_i(en), .trace_mode_i(mode), .trace_clear_i(clr),
        .trace_valid_i(valid), .trace_data_i(data),
        .trace_ptr_o(ptr_o), .trace_count_o(count_o),
        .trace_overflow_o(ovf_o), .trace_drop_cnt_o(drop_o),
        .trace_mem_en_i(mem_en), .trace_mem_addr_i(addr),
        .trace_mem_rdata_o(rdata_o)
    );

    always #5 clk = ~clk;

    // Reference model: buffer contents and status derived from the capture rules.
    logic [35:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];
    int          m_ptr, m_count, m_drop;
    bit          m_ovf, m_mode, m_en_prev, m_pend;
    logic [35:0] m_pd;

    function automatic void model_reset();
        m_ptr = 0; m_count = 0; m_drop = 0; m_ovf = 0;
        m_mode = 0; m_en_prev = 0; m_pend = 0; m_pd = '0;
    endfunction

    function automatic void model_step(bit i_en, bit i_valid, bit i_clr, bit i_mode, logic [35:0] i_data);
        bit start;
        start = i_en && !m_en_prev;
        if (start || i_clr) begin
            m_ptr = 0; m_count = 0; m_ovf = 0; m_drop = 0;
        end else if (m_pend) begin
            if (m_count == DEPTH) begin
                m_ovf = 1;
                if (m_mode) begin
                    m_mem[m_ptr] = m_pd; m_wr[m_ptr] = 1;
                    m_ptr = (m_ptr + 1) % DEPTH;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end else begin
                m_mem[m_ptr] = m_pd; m_wr[m_ptr] = 1;
                m_ptr = (m_ptr + 1) % DEPTH;
                m_count++;
            end
        end
        if (start) m_mode = i_mode;
        m_pend = i_en && i_valid;
        m_pd = i_data;
        m_en_prev = i_en;
    endfunction

    task automatic tick();
        bit s_en, s_valid, s_clr, s_mode;
        logic [35:0] s_data;
        s_en = en; s_valid = valid; s_clr = clr; s_mode = mode; s_data = data;
        @(posedge clk);
        if (reset_n) model_step(s_en, s_valid, s_clr, s_mode, s_data);
        else         model_reset();
        #1;
    endtask

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endfunction

    function automatic logic [35:0] tr(int i);
        return 36'h1_0000_0000 + 36'(i + 1);
    endfunction

    function automatic logic [127:0] row_of(logic [35:0] lo, logic [35:0] hi);
        return {28'h0, hi, 28'h0, lo};
    endfunction

    task automatic read_row(logic [31:0] a);
        mem_en = 1'b1; addr = a;
        tick();
        mem_en = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          n;
        bit          md;
        logic [31:0] rd_addr;
        int          lo_idx, hi_idx;
        int          e_ptr, e_count;
        bit          e_ovf;
        int          e_drop;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{"stop4",   4, 1'b0, 32'h00100010,  2,  3, 4, 4, 1'b0, 0};
        vecs[1] = '{"stop16", 16, 1'b0, 32'h001000F0, 14, 15, 0, 16, 1'b0, 0};
        vecs[2] = '{"stop17", 17, 1'b0, 32'h00100000,  0,  1, 0, 16, 1'b1, 1};
        vecs[3] = '{"stop20", 20, 1'b0, 32'h00100000,  0,  1, 0, 16, 1'b1, 4};
        vecs[4] = '{"wrap20", 20, 1'b1, 32'h00100000, 16, 17, 4, 16, 1'b1, 0};
        vecs[5] = '{"wrap16", 16, 1'b1, 32'h00100070, 14, 15, 0, 16, 1'b0, 0};
        vecs[6] = '{"wrap17", 17, 1'b1, 32'h00100100, 16,  1, 1, 16, 1'b1, 0};
        for (int i = 0; i < DEPTH; i++) begin m_wr[i] = 0; m_mem[i] = '0; end
        model_reset();

        // Reset state
        #12;
        chk("rst_ptr", 128'(ptr_o), 128'd0);
        chk("rst_count", 128'(count_o), 128'd0);
        chk("rst_ovf", 128'(ovf_o), 128'd0);
        chk("rst_drop", 128'(drop_o), 128'd0);
        chk("rst_rdata", rdata_o, 128'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Scenario table: fresh enable, n back-to-back traces, status + one row
        foreach (vecs[v]) begin
            en = 1'b0; valid = 1'b0; tick(); tick();
            en = 1'b1; mode = vecs[v].md;
            for (int i = 0; i < vecs[v].n; i++) begin
                valid = 1'b1; data = tr(i); tick();
            end
            valid = 1'b0; tick(); tick();
            chk({vecs[v].name, "_ptr"},   128'(ptr_o),   128'(vecs[v].e_ptr));
            chk({vecs[v].name, "_count"}, 128'(count_o), 128'(vecs[v].e_count));
            chk({vecs[v].name, "_ovf"},   128'(ovf_o),   128'(vecs[v].e_ovf));
            chk({vecs[v].name, "_drop"},  128'(drop_o),  128'(vecs[v].e_drop));
            read_row(vecs[v].rd_addr);
            chk({vecs[v].name, "_row"}, rdata_o, row_of(tr(vecs[v].lo_idx), tr(vecs[v].hi_idx)));
            tick();
            chk({vecs[v].name, "_row_hold"}, rdata_o, row_of(tr(vecs[v].lo_idx), tr(vecs[v].hi_idx)));
        end

        // Clear pulse with a valid trace in the same cycle (flags were set by wrap17)
        valid = 1'b1; data = 36'hA_AAAA_0001; tick();
        clr = 1'b1; data = 36'hB_BBBB_0002; tick();
        clr = 1'b0; valid = 1'b0;
        chk("clr_ptr", 128'(ptr_o), 128'd0);
        chk("clr_count", 128'(count_o), 128'd0);
        chk("clr_ovf", 128'(ovf_o), 128'd0);
        tick();
        chk("clr_next_ptr", 128'(ptr_o), 128'd1);
        chk("clr_next_count", 128'(count_o), 128'd1);
        read_row(32'h00100000);
        chk("clr_entry0", 128'(rdata_o[63:0]), 128'(36'hB_BBBB_0002));

        // Enable dropped for 5 cycles mid-burst, then re-enabled
        en = 1'b0; tick();
        en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 3; i++) begin valid = 1'b1; data = tr(40 + i); tick(); end
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            data = tr(50 + c); tick();
            chk($sformatf("dis_ptr_c%0d", c), 128'(ptr_o), 128'd3);
            chk($sformatf("dis_count_c%0d", c), 128'(count_o), 128'd3);
        end
        en = 1'b1; data = tr(60); tick();
        valid = 1'b0;
        chk("reen_ptr", 128'(ptr_o), 128'd0);
        chk("reen_count", 128'(count_o), 128'd0);
        tick();
        chk("reen_first_ptr", 128'(ptr_o), 128'd1);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) begin valid = 1'b1; data = tr(70 + i); tick(); end
        read_row(32'h00100000);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ptr", 128'(ptr_o), 128'd0);
        chk("arst_count", 128'(count_o), 128'd0);
        chk("arst_ovf", 128'(ovf_o), 128'd0);
        chk("arst_drop", 128'(drop_o), 128'd0);
        chk("arst_rdata", rdata_o, 128'd0);
        valid = 1'b0; en = 1'b0; tick(); tick();
        reset_n = 1'b1;
        en = 1'b1; valid = 1'b1; data = 36'hC_CCCC_0003; tick();
        valid = 1'b0; tick();
        chk("arst_after_ptr", 128'(ptr_o), 128'd1);
        read_row(32'h00100000);
        chk("arst_after_entry0", 128'(rdata_o[63:0]), 128'(36'hC_CCCC_0003));

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            en    = ($urandom_range(0, 31) != 0);
            valid = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 63) == 0);
            mode  = $urandom_range(0, 1) == 1;
            data  = {4'($urandom), 32'($urandom)};
            tick();
            tests++;
            if (ptr_o !== 32'(m_ptr) || count_o !== 32'(m_count) ||
                ovf_o !== m_ovf || drop_o !== 16'(m_drop)) begin
                fails++;
                $display("FAIL rand_c%0d: got ptr=%0d cnt=%0d ovf=%0d drop=%0d want ptr=%0d cnt=%0d ovf=%0d drop=%0d",
                         c, ptr_o, count_o, ovf_o, drop_o, m_ptr, m_count, m_ovf, m_drop);
            end
        end
        valid = 1'b0; clr = 1'b0; tick(); tick();
        for (int r = 0; r < DEPTH / 2; r++) begin
            read_row(32'h00100000 + 32'(r * 16));
            for (int k = 0; k < 2; k++) begin
                if (m_wr[2*r + k])
                    chk($sformatf("rand_row%0d_slot%0d", r, k), 128'(rdata_o[k*64 +: 64]), 128'(m_mem[2*r + k]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
